// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle for the SRAM slave.
//  master modport: drives address/control/write data and HREADY (mux output),
//                  samples HREADYOUT/HRESP/HRDATA.
//  slave modport : the reverse.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave wrapping a 2**DEPTH_LOG2 x 32-bit word memory.
//  HCLK    : bus clock, rising edge
//  HRESETn : asynchronous active-low reset
//  bus     : AHB-Lite slave port (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY in,
//            HREADYOUT/HRESP/HRDATA out)
// Byte/halfword/word transfers, WAIT_STATES data-phase wait cycles per OKAY
// transfer, two-cycle ERROR response for misaligned or oversized transfers.
module ahb_sram_slave #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input logic            HCLK,
  input logic            HRESETn,
  ahb_sram_slave_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} st_e;

  // Address-phase information carried into the data phase.
  typedef struct packed {
    logic [DEPTH_LOG2-1:0] idx;
    logic                  wr;
    logic [3:0]            lanes;
  } req_t;

  st_e        state_q, state_d;
  req_t       req_q, req_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hreadyout_q, hresp_q;
  logic [31:0] mem [DEPTH];

  logic       accept, legal;
  logic [3:0] lanes;

  // Only the IDLE and final data-phase cycles may open a new transfer; ERR2
  // deliberately ignores anything the master presents.
  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY &
                  ((state_q == ST_IDLE) | (state_q == ST_DATA));

  always_comb begin
    legal = 1'b0;
    lanes = 4'b0000;
    case (bus.HSIZE)
      3'b000: begin legal = 1'b1;                     lanes = 4'b0001 << bus.HADDR[1:0]; end
      3'b001: begin legal = ~bus.HADDR[0];            lanes = bus.HADDR[1] ? 4'b1100 : 4'b0011; end
      3'b010: begin legal = (bus.HADDR[1:0] == 2'b00); lanes = 4'b1111; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        state_d = ST_IDLE;
        if (accept) begin
          req_d.idx   = bus.HADDR[DEPTH_LOG2+1:2];
          req_d.wr    = bus.HWRITE;
          req_d.lanes = lanes;
          if (!legal)               state_d = ST_ERR1;
          else if (WAIT_STATES > 0) begin state_d = ST_WAIT; cnt_d = WS_LOAD; end
          else                      state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they change
  // cleanly at the edge that enters each state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= ~((state_d == ST_WAIT) | (state_d == ST_ERR1));
      hresp_q     <= (state_d == ST_ERR1) | (state_d == ST_ERR2);
    end
  end

  // Write commits at the edge closing the data phase, which is also the edge
  // accepting a pipelined follow-on read, so read-after-write needs no bypass.
  // Reset forces ST_IDLE, which drops a pending write.
  always_ff @(posedge HCLK) begin
    if (state_q == ST_DATA && req_q.wr) begin
      for (int i = 0; i < 4; i++)
        if (req_q.lanes[i]) mem[req_q.idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = (state_q == ST_DATA && !req_q.wr) ? mem[req_q.idx] : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[31:DEPTH_LOG2+2], bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with 0 wait states, one with 3.
// Stimulus pushes expected data-phase responses; a negedge monitor pops and
// compares when the selected slave closes a data phase.
module tb_ahb_sram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;   // 0: WAIT_STATES=0 slave, 1: WAIT_STATES=3 slave
  logic        stall = 1'b0; // another slave holding HREADY low
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [31:0] hwdata = '0;

  ahb_sram_slave_if b0 ();
  ahb_sram_slave_if b1 ();

  ahb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u0 (.HCLK(clk), .HRESETn(rst_n), .bus(b0));
  ahb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u1 (.HCLK(clk), .HRESETn(rst_n), .bus(b1));

  assign b0.HSEL = hsel & ~sel;   assign b1.HSEL = hsel & sel;
  assign b0.HADDR = haddr;        assign b1.HADDR = haddr;
  assign b0.HTRANS = htrans;      assign b1.HTRANS = htrans;
  assign b0.HWRITE = hwrite;      assign b1.HWRITE = hwrite;
  assign b0.HSIZE = hsize;        assign b1.HSIZE = hsize;
  assign b0.HWDATA = hwdata;      assign b1.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT & ~stall;
  assign b1.HREADY = b1.HREADYOUT & ~stall;

  logic        hrdy, hresp, hready_bus;
  logic [31:0] hrdata;
  assign hrdy       = sel ? b1.HREADYOUT : b0.HREADYOUT;
  assign hresp      = sel ? b1.HRESP     : b0.HRESP;
  assign hrdata     = sel ? b1.HRDATA    : b0.HRDATA;
  assign hready_bus = hrdy & ~stall;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Present one address phase and return #1 after the edge that accepts it;
  // the data-phase write data is then driven and the bus goes IDLE unless the
  // caller immediately issues the next transfer (pipelining).
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, input logic err, input logic [31:0] rexp,
                       input bit push);
    exp_t e;
    bit   r;
    int   n;
    if (push) begin
      e.rd = ~wr; e.err = err; e.data = rexp; e.waits = err ? 1 : (sel ? 3 : 0);
      q.push_back(e);
    end
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    n = 0;
    do begin
      @(negedge clk); r = hready_bus;
      @(posedge clk); #1; n++;
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", 32'(r), 32'd1);
    hwdata = wd; hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic idle(input int n);
    hsel = 1'b0; htrans = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a data phase is current from the negedge after an accept until
  // the slave raises HREADYOUT.
  initial begin
    bit   dp = 0, nxt = 0, bad = 0;
    int   lowcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp = 0; nxt = 0; bad = 0; lowcnt = 0;
      end else begin
        if (nxt) begin dp = 1; lowcnt = 0; bad = 0; end
        nxt = 0;
        if (dp) begin
          if (q.size() == 0) begin
            chk("unexpected_dphase", 32'd1, 32'd0);
            dp = 0;
          end else if (!hrdy) begin
            lowcnt++;
            if (hresp !== q[0].err) bad = 1;
          end else begin
            e = q.pop_front();
            chk("hresp", 32'(hresp), 32'(e.err));
            chk("wait_cycles", 32'(lowcnt), 32'(e.waits));
            chk("resp_in_wait", 32'(bad), 32'd0);
            if (e.rd) chk("hrdata", hrdata, e.data);
            dp = 0;
          end
        end else begin
          chk("idle_rdy_resp", {30'd0, hrdy, hresp}, 32'd2);
          chk("idle_rdata", hrdata, 32'h0);
        end
        if (hsel && htrans[1] && hready_bus) nxt = 1;
      end
    end
  end

  initial begin
    int n;
    // Reset state of both slaves
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy0", {31'd0, b0.HREADYOUT}, 32'd1);
    chk("rst_resp0", {31'd0, b0.HRESP}, 32'd0);
    chk("rst_rdata0", b0.HRDATA, 32'h0);
    chk("rst_rdy1", {31'd0, b1.HREADYOUT}, 32'd1);
    chk("rst_resp1", {31'd0, b1.HRESP}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Zero-wait slave: word write/read
    issue(1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0, 1);
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'hDEADBEEF, 1);
    idle(2);

    // Byte and halfword merges into one word
    issue(1, 32'h20, 3'b010, 32'h11223344, 0, 0, 1);
    issue(1, 32'h23, 3'b000, 32'hAA000000, 0, 0, 1);
    issue(1, 32'h20, 3'b001, 32'h00005566, 0, 0, 1);
    issue(0, 32'h20, 3'b010, 32'h0, 0, 32'hAA225566, 1);
    issue(0, 32'h23, 3'b000, 32'h0, 0, 32'hAA225566, 1);
    issue(1, 32'h40, 3'b010, 32'hCAFEF00D, 0, 0, 1);
    idle(2);

    // Illegal transfers: ERROR response, memory untouched
    issue(1, 32'h22, 3'b010, 32'hFFFFFFFF, 1, 0, 1);
    idle(3);
    issue(1, 32'h40, 3'b011, 32'hFFFFFFFF, 1, 0, 1);
    idle(3);
    issue(0, 32'h21, 3'b001, 32'h0, 1, 0, 1);
    idle(3);
    issue(0, 32'h20, 3'b010, 32'h0, 0, 32'hAA225566, 1);
    issue(0, 32'h40, 3'b010, 32'h0, 0, 32'hCAFEF00D, 1);
    idle(2);

    // Pipelined write then read of the same word
    issue(1, 32'h30, 3'b010, 32'h0BADF00D, 0, 0, 1);
    issue(0, 32'h30, 3'b010, 32'h0, 0, 32'h0BADF00D, 1);
    idle(2);

    // HREADY held low by another slave: transfer waits for it
    stall = 1'b1;
    fork
      begin repeat (3) @(posedge clk); #2; stall = 1'b0; end
    join_none
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'hDEADBEEF, 1);
    idle(3);

    // Three-wait-state slave
    sel = 1'b1;
    idle(1);
    issue(1, 32'h10, 3'b010, 32'hDEADBEEF, 0, 0, 1);
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'hDEADBEEF, 1);
    issue(1, 32'h50, 3'b010, 32'h00000000, 0, 0, 1);
    issue(0, 32'h50, 3'b010, 32'h0, 0, 32'h0, 1);
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    idle(2);

    // Reset during the wait phase of a write drops the write
    issue(1, 32'h50, 3'b010, 32'h12345678, 0, 0, 0);
    chk("in_wait_rdy", {31'd0, b1.HREADYOUT}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_rdy", {31'd0, b1.HREADYOUT}, 32'd1);
    chk("rst_mid_resp", {31'd0, b1.HRESP}, 32'd0);
    chk("rst_mid_rdata", b1.HRDATA, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    issue(0, 32'h50, 3'b010, 32'h0, 0, 32'h0, 1);
    issue(0, 32'h10, 3'b010, 32'h0, 0, 32'hDEADBEEF, 1);
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    chk("queue_drained", 32'(q.size()), 32'd0);
    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
